// File: rtl/uart_rx_byte_fifo.sv
// Receive byte FIFO behind the UART: tags each byte with its framing error, FWFT pop side.
// Optional idle-timeout interrupt built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_byte_fifo #(
   parameter int DATA_WIDTH        = 8,
   parameter int DEPTH             = 16,
   parameter int ALMOST_FULL_LEVEL = 12,
   parameter int TIMEOUT_CYCLES    = 5556
) (
   input  logic                          clk_16mhz,
   input  logic                          rstn,
   input  logic [DATA_WIDTH-1:0]         rx_data_in,
   input  logic                          rx_done_pulse,
   input  logic                          rx_error,
   input  logic                          rd_en,
   input  logic                          flush,
   input  logic                          clr_overflow,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          rd_data_err,
   output logic                          rd_valid,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          almost_full,
   output logic                          overflow,
   output logic                          timeout_irq
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ALMOST_FULL_LEVEL > DEPTH ||
       TIMEOUT_CYCLES < 1) begin : g_param_chk
      $error("uart_rx_byte_fifo: illegal parameter combination");
   end

   logic [DATA_WIDTH:0] mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    cnt_q;
   logic                overflow_q;
   logic                do_push;
   logic                do_pop;
   logic                drop;
   logic [DATA_WIDTH:0] head;

   // A pop in the same cycle frees the slot, so a push at full is still accepted.
   assign do_pop  = rd_en & (cnt_q != '0);
   assign do_push = rx_done_pulse & ((cnt_q != CNT_W'(DEPTH)) | do_pop);
   assign drop    = rx_done_pulse & ~do_push;

   always_ff @(posedge clk_16mhz) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
         else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_16mhz) begin
      if (do_push && !flush) mem[wr_ptr] <= {rx_error, rx_data_in};
   end

   // A drop beats a same-cycle clear; a drop discarded by flush does not count.
   always_ff @(posedge clk_16mhz) begin
      if (!rstn)                overflow_q <= 1'b0;
      else if (drop && !flush)  overflow_q <= 1'b1;
      else if (clr_overflow)    overflow_q <= 1'b0;
   end

   assign head        = mem[rd_ptr];
   assign rd_valid    = (cnt_q != '0);
   assign rd_data     = rd_valid ? head[DATA_WIDTH-1:0] : '0;
   assign rd_data_err = rd_valid & head[DATA_WIDTH];
   assign count       = cnt_q;
   assign almost_full = (cnt_q >= CNT_W'(ALMOST_FULL_LEVEL));
   assign overflow    = overflow_q;

`ifdef UART_RX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] idle_cnt;
   logic [TO_W-1:0] idle_cnt_nxt;
   logic            irq_q;

   always_comb begin
      idle_cnt_nxt = idle_cnt;
      if (flush || do_push || do_pop || cnt_q == '0)
         idle_cnt_nxt = '0;
      else if (idle_cnt != TO_W'(TIMEOUT_CYCLES))
         idle_cnt_nxt = idle_cnt + TO_W'(1);
   end

   always_ff @(posedge clk_16mhz) begin
      if (!rstn) begin
         idle_cnt <= '0;
         irq_q    <= 1'b0;
      end else begin
         idle_cnt <= idle_cnt_nxt;
         irq_q    <= (idle_cnt_nxt == TO_W'(TIMEOUT_CYCLES));
      end
   end

   assign timeout_irq = irq_q;
`else
   assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Directed bench for uart_rx_byte_fifo; expected values are hand-derived constants.
`timescale 1ns/1ps
module tb_uart_rx_byte_fifo;

   logic       clk_16mhz;
   logic       rstn;
   logic [7:0] rx_data_in;
   logic       rx_done_pulse;
   logic       rx_error;
   logic       rd_en;
   logic       flush;
   logic       clr_overflow;
   logic [7:0] rd_data;
   logic       rd_data_err;
   logic       rd_valid;
   logic [4:0] count;
   logic       almost_full;
   logic       overflow;
   logic       timeout_irq;

   int n_chk;
   int n_fail;

`ifdef UART_RX_TIMEOUT_EN
   localparam logic TO_EXP = 1'b1;
`else
   localparam logic TO_EXP = 1'b0;
`endif

   uart_rx_byte_fifo dut (
      .clk_16mhz    (clk_16mhz),
      .rstn         (rstn),
      .rx_data_in   (rx_data_in),
      .rx_done_pulse(rx_done_pulse),
      .rx_error     (rx_error),
      .rd_en        (rd_en),
      .flush        (flush),
      .clr_overflow (clr_overflow),
      .rd_data      (rd_data),
      .rd_data_err  (rd_data_err),
      .rd_valid     (rd_valid),
      .count        (count),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .timeout_irq  (timeout_irq)
   );

   initial clk_16mhz = 1'b0;
   always #31 clk_16mhz = ~clk_16mhz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_16mhz);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic e);
      rx_data_in    = d;
      rx_error      = e;
      rx_done_pulse = 1'b1;
      tick();
      rx_done_pulse = 1'b0;
      rx_error      = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rstn = 1'b0;
      rx_data_in = '0;
      rx_done_pulse = 1'b0;
      rx_error = 1'b0;
      rd_en = 1'b0;
      flush = 1'b0;
      clr_overflow = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      chk("init_count", count, 0);
      chk("init_valid", rd_valid, 0);

      // reset mid-traffic
      for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 1'b0);
      chk("pre_rst_count", count, 5);
      chk("pre_rst_data", rd_data, 8'h10);
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      chk("rst_count", count, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_data", rd_data, 0);
      chk("rst_err", rd_data_err, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_irq", timeout_irq, 0);
      chk("rst_af", almost_full, 0);

      // ordered read-back
      push(8'h41, 1'b0);
      push(8'h42, 1'b0);
      push(8'h43, 1'b0);
      chk("ord_count3", count, 3);
      chk("ord_d0", rd_data, 8'h41);
      pop();
      chk("ord_count2", count, 2);
      chk("ord_d1", rd_data, 8'h42);
      pop();
      chk("ord_count1", count, 1);
      chk("ord_d2", rd_data, 8'h43);
      pop();
      chk("ord_count0", count, 0);
      chk("ord_valid", rd_valid, 0);
      chk("ord_data0", rd_data, 0);

      // fill past full
      for (int i = 0; i < 17; i++) begin
         push(8'(i), 1'b0);
         chk("fill_count", count, (i + 1 > 16) ? 16 : i + 1);
         chk("fill_af", almost_full, (i + 1 >= 12) ? 1 : 0);
         chk("fill_ovf", overflow, (i == 16) ? 1 : 0);
      end
      for (int i = 0; i < 16; i++) begin
         chk("drain_data", rd_data, i);
         pop();
      end
      chk("drain_valid", rd_valid, 0);
      chk("drain_ovf_sticky", overflow, 1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      chk("clr_ovf", overflow, 0);

      // push with pop at full
      for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1'b0);
      rx_data_in = 8'hAA;
      rx_done_pulse = 1'b1;
      rd_en = 1'b1;
      tick();
      rx_done_pulse = 1'b0;
      rd_en = 1'b0;
      chk("fullpp_count", count, 16);
      chk("fullpp_ovf", overflow, 0);
      for (int j = 1; j < 16; j++) begin
         chk("fullpp_data", rd_data, 8'h80 + j);
         pop();
      end
      chk("fullpp_last", rd_data, 8'hAA);
      pop();
      chk("fullpp_empty", count, 0);

      // drop and clear same cycle: set wins; flush keeps overflow
      for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
      clr_overflow = 1'b1;
      push(8'hEE, 1'b0);
      clr_overflow = 1'b0;
      chk("setwin_ovf", overflow, 1);
      chk("setwin_count", count, 16);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_count", count, 0);
      chk("flush_ovf", overflow, 1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      chk("flush_clr", overflow, 0);

      // push+pop at empty
      rx_data_in = 8'h3C;
      rx_done_pulse = 1'b1;
      rd_en = 1'b1;
      tick();
      rx_done_pulse = 1'b0;
      rd_en = 1'b0;
      chk("emptypp_count", count, 1);
      chk("emptypp_data", rd_data, 8'h3C);
      pop();

      // error tagging
      push(8'h55, 1'b1);
      push(8'h66, 1'b0);
      chk("err_d0", rd_data, 8'h55);
      chk("err_e0", rd_data_err, 1);
      pop();
      chk("err_d1", rd_data, 8'h66);
      chk("err_e1", rd_data_err, 0);
      pop();
      chk("err_empty", count, 0);

      // idle timeout
      push(8'h77, 1'b0);
      for (int i = 0; i < 5555; i++) tick();
      chk("to_early", timeout_irq, 0);
      tick();
      chk("to_fire", timeout_irq, TO_EXP);
      tick();
      chk("to_level", timeout_irq, TO_EXP);
      pop();
      chk("to_clr_pop", timeout_irq, 0);
      push(8'h01, 1'b0);
      rx_data_in = 8'h02;
      rx_done_pulse = 1'b1;
      flush = 1'b1;
      tick();
      rx_done_pulse = 1'b0;
      flush = 1'b0;
      chk("to_flushpush", count, 0);
      chk("to_flush_irq", timeout_irq, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
